sram32_ctrl: RTL

Bus-side initiator for the board's two IDT71V416 asynchronous 256K×16 SRAMs, wired as one 32-bit-wide memory. It turns single-word CPU requests into glitch-free SRAM pin sequences on the shared address and strobes. It drives the per-chip byte lanes and the two bidirectional 16-bit data buses. It sits between the CPU core and the SRAM pins, and is the counterpart of the memory models in the gate-level simulation bench.

---
 rtl/sram32_ctrl_if.sv | 27 ++
 rtl/sram32_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sram32_ctrl_if.sv
// CPU-side single-word request bus for sram32_ctrl.
//   cyc_stb_i : request valid, held by the master until ack_o
//   we_i      : 1 = write, 0 = read
//   adr_i     : 32-bit word address (18 bits)
//   dat_i     : write data, [15:0] -> chip 0, [31:16] -> chip 1
//   sel_i     : byte enables for writes, active-high
//   dat_o     : read data, valid while ack_o = 1
//   ack_o     : one-cycle completion pulse
interface sram32_ctrl_if;
  logic        cyc_stb_i;
  logic        we_i;
  logic [17:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output cyc_stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  cyc_stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/sram32_ctrl.sv
// Bus-side initiator for two asynchronous 256Kx16 SRAMs wired as one
// 32-bit-wide memory. Turns single-word requests into glitch-free SRAM
// pin sequences.
//   clk_, rst_         : clock, asynchronous active-low reset
//   bus (slave)        : CPU request/response bus (sram32_ctrl_if)
//   addr_              : shared SRAM address
//   rcs_, roe_, rwe_   : shared chip select / output enable / write enable
//   rble0_, rbhe0_     : chip 0 byte-lane enables (sel[0], sel[1])
//   rble1_, rbhe1_     : chip 1 byte-lane enables (sel[2], sel[3])
//   data0_, data1_     : bidirectional 16-bit SRAM data buses
// RD_WAIT / WR_WAIT (0..7) stretch the read / write strobes by that many
// extra cycles.
module sram32_ctrl #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic         clk_,
  input  logic         rst_,
  sram32_ctrl_if.slave bus,
  output logic [17:0]  addr_,
  output logic         rcs_,
  output logic         roe_,
  output logic         rwe_,
  output logic         rble0_,
  output logic         rbhe0_,
  output logic         rble1_,
  output logic         rbhe1_,
  inout  wire  [15:0]  data0_,
  inout  wire  [15:0]  data1_
);

  typedef enum logic [2:0] {IDLE, RD, WS, WP, WH, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [3:0]  sel_q, sel_nx;
  logic [31:0] wdata_q, wdata_nx;
  logic [17:0] addr_nx;
  logic        capture;
  logic        rcs_nx, roe_nx, rwe_nx;
  logic [3:0]  lanes_q, lanes_nx;
  logic        bus_oe, bus_oe_nx;
  logic        ack_q, ack_nx;
  logic [31:0] rdata_q;

  // Next-state and counter logic. On accept, the request fields are
  // taken straight from the bus so the pins can be registered in the
  // same edge that moves the FSM out of IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel_q;
    wdata_nx = wdata_q;
    addr_nx  = addr_;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cyc_stb_i) begin
          addr_nx  = bus.adr_i;
          sel_nx   = bus.sel_i;
          wdata_nx = bus.dat_i;
          if (bus.we_i) begin
            state_nx = WS;
            cnt_nx   = 3'(WR_WAIT);
          end else begin
            state_nx = RD;
            cnt_nx   = 3'(RD_WAIT);
          end
        end
      end
      RD: begin
        if (cnt == 3'd0) begin
          state_nx = DONE;
          capture  = 1'b1;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      WS: state_nx = WP;
      WP: begin
        if (cnt == 3'd0) state_nx = WH;
        else             cnt_nx   = cnt - 3'd1;
      end
      WH:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered, then registered,
  // so every SRAM pin comes straight from a flop and reflects the current
  // state without any input-to-pin combinational path.
  always_comb begin
    rcs_nx    = 1'b1;
    roe_nx    = 1'b1;
    rwe_nx    = 1'b1;
    lanes_nx  = '1;
    bus_oe_nx = 1'b0;
    ack_nx    = 1'b0;
    case (state_nx)
      RD: begin
        rcs_nx   = 1'b0;
        roe_nx   = 1'b0;
        lanes_nx = '0;
      end
      WS, WH: begin
        rcs_nx    = 1'b0;
        lanes_nx  = ~sel_nx;
        bus_oe_nx = 1'b1;
      end
      WP: begin
        rcs_nx    = 1'b0;
        rwe_nx    = 1'b0;
        lanes_nx  = ~sel_nx;
        bus_oe_nx = 1'b1;
      end
      DONE:    ack_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_ or negedge rst_) begin
    if (!rst_) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      addr_   <= '0;
      rcs_    <= 1'b1;
      roe_    <= 1'b1;
      rwe_    <= 1'b1;
      lanes_q <= '1;
      bus_oe  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sel_q   <= sel_nx;
      wdata_q <= wdata_nx;
      addr_   <= addr_nx;
      rcs_    <= rcs_nx;
      roe_    <= roe_nx;
      rwe_    <= rwe_nx;
      lanes_q <= lanes_nx;
      bus_oe  <= bus_oe_nx;
      ack_q   <= ack_nx;
      if (capture) rdata_q <= {data1_, data0_};
    end
  end

  assign rble0_ = lanes_q[0];
  assign rbhe0_ = lanes_q[1];
  assign rble1_ = lanes_q[2];
  assign rbhe1_ = lanes_q[3];

  assign data0_ = bus_oe ? wdata_q[15:0]  : 'z;
  assign data1_ = bus_oe ? wdata_q[31:16] : 'z;

  assign bus.dat_o = rdata_q;
  assign bus.ack_o = ack_q;

endmodule
